// File: rtl/dvi_pkg.sv
// dvi_pkg: shared DVI/TMDS widths, control tokens and receiver types.
// Imported by the TMDS receive channel and its decoder.
package dvi_pkg;

  localparam int COLOR_W = 8;
  localparam int TMDS_W  = 10;
  localparam int OFS_W   = 4;

  localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  localparam logic [OFS_W-1:0] OFS_LAST = 4'd9;

  typedef enum logic {
    SEARCH,
    LOCKED
  } tmds_rx_state_t;

  function automatic logic [OFS_W-1:0] next_offset(
    input logic [OFS_W-1:0] ofs
  );
    return (ofs == OFS_LAST) ? '0 : ofs + OFS_W'(1);
  endfunction

endpackage

// File: rtl/tmds_decoder.sv
// tmds_decoder: combinational TMDS symbol decode to token flags or data.
// Reused by the receive channel and TMDS checkers.
module tmds_decoder
  import dvi_pkg::*;
(
  input  logic [TMDS_W-1:0]  sym_i,
  output logic               is_token_o,
  output logic               c1_o,
  output logic               c0_o,
  output logic [COLOR_W-1:0] d_o
);

  logic [8:0] q;

  always_comb begin
    is_token_o = 1'b1;
    c1_o       = 1'b0;
    c0_o       = 1'b0;
    unique case (1'b1)
      (sym_i == CTRL_TOKEN_00): begin
        c1_o = 1'b0;
        c0_o = 1'b0;
      end
      (sym_i == CTRL_TOKEN_01): begin
        c1_o = 1'b0;
        c0_o = 1'b1;
      end
      (sym_i == CTRL_TOKEN_10): begin
        c1_o = 1'b1;
        c0_o = 1'b0;
      end
      (sym_i == CTRL_TOKEN_11): begin
        c1_o = 1'b1;
        c0_o = 1'b1;
      end
      default: is_token_o = 1'b0;
    endcase
  end

  // bit 9 flags inversion of the low byte; bit 8 picks XOR vs XNOR chain
  always_comb begin
    q = sym_i[9] ? {sym_i[8], ~sym_i[7:0]}
                 : sym_i[8:0];
    d_o    = '0;
    d_o[0] = q[0];
    for (int i = 1; i < COLOR_W; i++) begin
      d_o[i] = q[8] ? (q[i] ^ q[i-1])
                    : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: word aligner and decoder for one TMDS data channel.
// Define TMDS_RX_RELOCK_CNT_EN to add the relock_cnt_o lock-loss counter.
module tmds_rx_channel
  import dvi_pkg::*;
#(
  parameter int DWELL_CYCLES = 4096,
  parameter int LOCK_CNT     = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [TMDS_W-1:0]  raw_i,
  output logic [COLOR_W-1:0] data_o,
  output logic               c0_o,
  output logic               c1_o,
  output logic               de_o,
  output logic               locked_o,
  output logic [OFS_W-1:0]   offset_o
`ifdef TMDS_RX_RELOCK_CNT_EN
  ,
  output logic [7:0]         relock_cnt_o
`endif
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam int RN_W = $clog2(LOCK_CNT + 1);

  localparam logic [DW_W-1:0] DWELL_MAX =
    DW_W'(DWELL_CYCLES - 1);
  localparam logic [RN_W-1:0] RUN_MAX =
    RN_W'(LOCK_CNT);

  tmds_rx_state_t     state_q, state_d;
  logic [TMDS_W-1:0]  raw_q;
  logic [OFS_W-1:0]   offset_q, offset_d;
  logic [RN_W-1:0]    run_q, run_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               c0_q, c0_d;
  logic               c1_q, c1_d;
  logic               de_q, de_d;
  logic               locked_q, locked_d;

  logic [2*TMDS_W-1:0] win;
  logic [TMDS_W-1:0]   sym;
  logic                tok;
  logic                tok_c1;
  logic                tok_c0;
  logic [COLOR_W-1:0]  dec_d;
  logic                hit;
  logic                expire;

  // older word sits in the low half: bit 0 arrived first
  assign win = {raw_i, raw_q};
  assign sym = win[{1'b0, offset_q} +: TMDS_W];

  tmds_decoder u_dec (
    .sym_i      (sym),
    .is_token_o (tok),
    .c1_o       (tok_c1),
    .c0_o       (tok_c0),
    .d_o        (dec_d)
  );

  always_comb begin
    run_d = '0;
    if (tok) begin
      run_d = (run_q == RUN_MAX) ? run_q
                                 : run_q + RN_W'(1);
    end
    hit    = tok && (run_d == RUN_MAX);
    expire = (dwell_q == DWELL_MAX);

    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q + DW_W'(1);

    // lock or refresh beats the dwell timeout in the same cycle
    unique case (state_q)
      SEARCH: begin
        if (hit) begin
          state_d = LOCKED;
          dwell_d = '0;
        end else if (expire) begin
          offset_d = next_offset(offset_q);
          run_d    = '0;
          dwell_d  = '0;
        end
      end
      LOCKED: begin
        if (hit) begin
          dwell_d = '0;
        end else if (expire) begin
          state_d  = SEARCH;
          offset_d = next_offset(offset_q);
          run_d    = '0;
          dwell_d  = '0;
        end
      end
    endcase

    locked_d = (state_d == LOCKED);
    de_d     = locked_d && !tok;
    c0_d     = locked_d && tok && tok_c0;
    c1_d     = locked_d && tok && tok_c1;
    data_d   = de_d ? dec_d : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEARCH;
      raw_q    <= '0;
      offset_q <= '0;
      run_q    <= '0;
      dwell_q  <= '0;
      data_q   <= '0;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      raw_q    <= raw_i;
      offset_q <= offset_d;
      run_q    <= run_d;
      dwell_q  <= dwell_d;
      data_q   <= data_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign data_o   = data_q;
  assign c0_o     = c0_q;
  assign c1_o     = c1_q;
  assign de_o     = de_q;
  assign locked_o = locked_q;
  assign offset_o = offset_q;

`ifdef TMDS_RX_RELOCK_CNT_EN
  logic [7:0] relock_q, relock_d;

  always_comb begin
    relock_d = relock_q;
    if (state_q == LOCKED && state_d == SEARCH &&
        relock_q != 8'hFF) begin
      relock_d = relock_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt_o = relock_q;
`endif

endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: scoreboard bench for the TMDS receive channel.
// Relock counter scenario runs when TMDS_RX_RELOCK_CNT_EN is defined.
module tb_tmds_rx_channel;

  localparam int DWELL = 64;
  localparam int LCNT  = 8;
  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] DAT = 10'h100;

  typedef struct packed {
    bit       chk;
    bit       de;
    bit       c1;
    bit       c0;
    bit [7:0] d;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] raw;
  logic [7:0] data;
  logic       c0;
  logic       c1;
  logic       de;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_RX_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  int pass_cnt;
  int total_cnt;
  exp_t sbq[$];

  tmds_rx_channel #(
    .DWELL_CYCLES (DWELL),
    .LOCK_CNT     (LCNT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .raw_i        (raw),
    .data_o       (data),
    .c0_o         (c0),
    .c1_o         (c1),
    .de_o         (de),
    .locked_o     (locked),
    .offset_o     (offset)
`ifdef TMDS_RX_RELOCK_CNT_EN
    ,
    .relock_cnt_o (relock_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] rotl(input logic [9:0] v,
                                      input int k);
    logic [9:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  function automatic bit is_tok(input logic [9:0] s);
    return s == 10'h354 || s == 10'h0AB ||
           s == 10'h154 || s == 10'h2AB;
  endfunction

  function automatic exp_t model(input logic [9:0] s);
    exp_t e;
    logic [7:0] b;
    e = '0;
    e.chk = 1'b1;
    case (s)
      10'h354: e.c0 = 1'b0;
      10'h0AB: e.c0 = 1'b1;
      10'h154: e.c1 = 1'b1;
      10'h2AB: begin e.c1 = 1'b1; e.c0 = 1'b1; end
      default: begin
        e.de = 1'b1;
        b = s[9] ? ~s[7:0] : s[7:0];
        e.d[0] = b[0];
        for (int i = 1; i < 8; i++)
          e.d[i] = b[i] ^ b[i-1] ^ ~s[8];
      end
    endcase
    return e;
  endfunction

  task automatic do_reset(input logic [9:0] w);
    @(negedge clk);
    rst_n = 1'b0;
    raw   = w;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_at0();
    int n;
    do_reset(T00);
    n = 0;
    while (!locked && n < 3 * LCNT) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (locked !== 1'b1)
      $display("FAIL lock_at0: locked=%b want 1", locked);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw = T00;
    #1;
    total_cnt++;
    if ({data, c1, c0, de, locked, offset} !== 16'h0)
      $display("FAIL por_outputs: got %h want 0",
               {data, c1, c0, de, locked, offset});
    else pass_cnt++;
    lock_at0();
    @(negedge clk);
    raw = 10'h0FF;
    @(negedge clk);
    raw = T00;
    @(negedge clk);
    total_cnt++;
    if ({de, data} !== 9'h1FF)
      $display("FAIL pre_reset_data: de/data=%h want 1ff",
               {de, data});
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({data, c1, c0, de, locked, offset} !== 16'h0)
      $display("FAIL mid_reset: got %h want 0",
               {data, c1, c0, de, locked, offset});
    else pass_cnt++;
  endtask

  task automatic test_search_lock();
    int n;
    do_reset(rotl(T00, 3));
    n = 0;
    while (!locked && n < 3 * DWELL + LCNT + 2) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (locked !== 1'b1)
      $display("FAIL search_lock: locked=%b after %0d",
               locked, n);
    else pass_cnt++;
    total_cnt++;
    if ({offset, de, c1, c0} !== {4'd3, 3'b000})
      $display("FAIL search_state: ofs=%0d dcc=%b want 3/000",
               offset, {de, c1, c0});
    else pass_cnt++;
  endtask

  task automatic run_sb(input logic [9:0] ws[$],
                        input string tag);
    exp_t e;
    exp_t o;
    sbq.delete();
    foreach (ws[k]) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        o = '0;
        o.chk = 1'b1;
        o.de = de;
        o.c1 = c1;
        o.c0 = c0;
        o.d  = de ? data : 8'h00;
        if (!e.de) e.d = 8'h00;
        total_cnt++;
        if (o !== e)
          $display("FAIL %s[%0d]: got %h want %h",
                   tag, k, o, e);
        else pass_cnt++;
      end
      sbq.push_back(model(ws[k]));
      raw = ws[k];
    end
    sbq.delete();
  endtask

  task automatic test_tokens();
    logic [9:0] ws[$];
    logic [9:0] lead[4];
    lead = '{10'h0AB, 10'h154, 10'h2AB, 10'h100};
    lock_at0();
    for (int i = 0; i < 4; i++) begin
      ws.push_back(lead[i]);
      repeat (16) ws.push_back(T00);
    end
    run_sb(ws, "tokens");
    total_cnt++;
    if ({locked, offset} !== 5'h10)
      $display("FAIL tokens_hold: lk/ofs=%h want 10",
               {locked, offset});
    else pass_cnt++;
  endtask

  task automatic test_data();
    logic [9:0] ws[$];
    logic [9:0] w;
    for (int i = 0; i < 8; i++) begin
      do w = 10'($urandom_range(0, 1023));
      while (is_tok(w));
      ws.push_back(w);
      repeat (10) ws.push_back(T00);
    end
    run_sb(ws, "data");
  endtask

  task automatic test_timeout_wrap();
    int n;
    do_reset(rotl(T00, 9));
    n = 0;
    while (!locked && n < 9 * DWELL + LCNT + 4) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if ({locked, offset} !== {1'b1, 4'd9})
      $display("FAIL lock9: lk/ofs=%h want 19",
               {locked, offset});
    else pass_cnt++;
    raw = DAT;
    n = 0;
    while (locked && n < DWELL + 16) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n < DWELL - 4 || n > DWELL + 6)
      $display("FAIL loss_time: %0d cycles want ~%0d",
               n, DWELL);
    else pass_cnt++;
    total_cnt++;
    if ({locked, offset} !== 5'h00)
      $display("FAIL wrap: lk/ofs=%h want 00",
               {locked, offset});
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if ({de, c1, c0} !== 3'b000)
        $display("FAIL unlocked_gate[%0d]: dcc=%b want 000",
                 i, {de, c1, c0});
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_lock_vs_dwell();
    @(negedge clk);
    rst_n = 1'b0;
    raw = DAT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 64; s++) begin
      @(negedge clk);
      raw = (s >= 55) ? T00 : DAT;
      if (s == 63) begin
        total_cnt++;
        if (locked !== 1'b0)
          $display("FAIL early_lock: locked=%b want 0",
                   locked);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({locked, offset} !== 5'h10)
      $display("FAIL lock_vs_dwell: lk/ofs=%h want 10",
               {locked, offset});
    else pass_cnt++;
  endtask

`ifdef TMDS_RX_RELOCK_CNT_EN
  task automatic lose_once(inout int o, inout int bad);
    int n;
    raw = rotl(T00, o);
    n = 0;
    while (!locked && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!locked || offset != 4'(o)) bad++;
    raw = DAT;
    n = 0;
    while (locked && n < DWELL + 16) begin
      @(negedge clk);
      n++;
    end
    if (locked) bad++;
    o = (o + 1) % 10;
  endtask

  task automatic test_relock();
    int o;
    int bad;
    do_reset(DAT);
    o = 0;
    bad = 0;
    for (int i = 0; i < 300; i++) lose_once(o, bad);
    total_cnt++;
    if (bad !== 0)
      $display("FAIL relock_loop: %0d bad iters want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (relock_cnt !== 8'd255)
      $display("FAIL relock_sat: got %0d want 255",
               relock_cnt);
    else pass_cnt++;
    lose_once(o, bad);
    total_cnt++;
    if (relock_cnt !== 8'd255)
      $display("FAIL relock_hold: got %0d want 255",
               relock_cnt);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (relock_cnt !== 8'd0)
      $display("FAIL relock_rst: got %0d want 0",
               relock_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    raw   = T00;
    test_reset();
    test_search_lock();
    test_tokens();
    test_data();
    test_timeout_wrap();
    test_lock_vs_dwell();
`ifdef TMDS_RX_RELOCK_CNT_EN
    test_relock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
